// File: rtl/rob_mem_responder.sv
// ROB commit-time memory responder: per-entry address table plus a single-outstanding d-cache FSM.
// Optional misaligned-access drop is enabled with `define MEM_MISALIGN_CHECK_EN.
module rob_mem_responder #(
    parameter int ROB_DEPTH = 8,
    parameter int PTR_W     = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 agu_valid,
    input  logic [PTR_W-1:0]     agu_rob_idx,
    input  logic [31:0]          agu_addr,
    input  logic [31:0]          agu_store_data,
    input  logic [2:0]           agu_funct3,
    input  logic [ROB_DEPTH-1:0] flush_mask,
    input  logic [PTR_W-1:0]     head_ptr,
    input  logic                 data_read,
    input  logic                 data_write,
    output logic                 data_mem_resp,
    output logic [31:0]          ld_data,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [31:0]          mem_address,
    output logic [31:0]          mem_wdata,
    output logic [3:0]           mem_byte_enable,
    input  logic [31:0]          mem_rdata,
    input  logic                 mem_resp,
    output logic                 misaligned
);

    // state  | meaning
    // IDLE   | waiting for a commit request on a valid head entry
    // ACCESS | d-cache request held until mem_resp
    // DONE   | one-cycle data_mem_resp, head entry retired
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [ROB_DEPTH-1:0] tbl_valid;
    logic [31:0]          tbl_addr [ROB_DEPTH];
    logic [31:0]          tbl_data [ROB_DEPTH];
    logic [2:0]           tbl_f3   [ROB_DEPTH];

    logic [PTR_W-1:0] req_idx;
    logic [2:0]       req_f3;
    logic [1:0]       req_off;
    logic             req_read;

    logic [31:0] head_addr;
    logic [31:0] head_data;
    logic [2:0]  head_f3;
    logic        head_go;
    logic        start;
    logic        done_clr;
    logic        misalign_hit;

    logic        mem_read_nxt;
    logic        mem_write_nxt;
    logic [31:0] addr_nxt;
    logic [31:0] wdata_nxt;
    logic [3:0]  be_nxt;
    logic        resp_nxt;
    logic [31:0] ld_nxt;

    function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] m;
        case (f3[1:0])
            2'b00:   m = 4'b0001 << off;
            2'b01:   m = 4'b0011 << off;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] lane_data(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] w;
        case (f3[1:0])
            2'b00:   w = {4{d[7:0]}};
            2'b01:   w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] rdata);
        logic [31:0] sh;
        logic [31:0] r;
        sh = rdata >> {off, 3'b000};
        case (f3)
            3'b000:  r = {{24{sh[7]}}, sh[7:0]};
            3'b001:  r = {{16{sh[15]}}, sh[15:0]};
            3'b100:  r = {24'd0, sh[7:0]};
            3'b101:  r = {16'd0, sh[15:0]};
            default: r = rdata;
        endcase
        return r;
    endfunction

    assign head_addr = tbl_addr[head_ptr];
    assign head_data = tbl_data[head_ptr];
    assign head_f3   = tbl_f3[head_ptr];
    assign head_go   = (data_read | data_write) & tbl_valid[head_ptr];
    assign done_clr  = (state == ST_DONE);

`ifdef MEM_MISALIGN_CHECK_EN
    assign misalign_hit = ((head_f3[1:0] == 2'b01) && head_addr[0]) ||
                          ((head_f3[1:0] == 2'b10) && (head_addr[1:0] != 2'b00));

    always_ff @(posedge clk) begin
        if (rst) misaligned <= 1'b0;
        else     misaligned <= (state == ST_IDLE) && head_go && misalign_hit;
    end
`else
    assign misalign_hit = 1'b0;
    assign misaligned   = 1'b0;
`endif

    // Same-index priority: agu write, then DONE retire, then flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            tbl_valid <= '0;
        end else begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                if (agu_valid && (agu_rob_idx == PTR_W'(i)))
                    tbl_valid[i] <= 1'b1;
                else if (done_clr && (req_idx == PTR_W'(i)))
                    tbl_valid[i] <= 1'b0;
                else if (flush_mask[i])
                    tbl_valid[i] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (agu_valid) begin
            tbl_addr[agu_rob_idx] <= agu_addr;
            tbl_data[agu_rob_idx] <= agu_store_data;
            tbl_f3[agu_rob_idx]   <= agu_funct3;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            mem_read        <= 1'b0;
            mem_write       <= 1'b0;
            mem_address     <= '0;
            mem_wdata       <= '0;
            mem_byte_enable <= '0;
            data_mem_resp   <= 1'b0;
            ld_data         <= '0;
            req_idx         <= '0;
            req_f3          <= '0;
            req_off         <= '0;
            req_read        <= 1'b0;
        end else begin
            state           <= state_nxt;
            mem_read        <= mem_read_nxt;
            mem_write       <= mem_write_nxt;
            mem_address     <= addr_nxt;
            mem_wdata       <= wdata_nxt;
            mem_byte_enable <= be_nxt;
            data_mem_resp   <= resp_nxt;
            ld_data         <= ld_nxt;
            if (start) begin
                req_idx  <= head_ptr;
                req_f3   <= head_f3;
                req_off  <= head_addr[1:0];
                req_read <= data_read;
            end
        end
    end

    // Outputs are registered: next values are built here, held only while in ACCESS.
    always_comb begin
        state_nxt     = state;
        start         = 1'b0;
        mem_read_nxt  = 1'b0;
        mem_write_nxt = 1'b0;
        addr_nxt      = '0;
        wdata_nxt     = '0;
        be_nxt        = '0;
        resp_nxt      = 1'b0;
        ld_nxt        = '0;
        case (state)
            ST_IDLE: begin
                if (head_go) begin
                    start = 1'b1;
                    if (misalign_hit) begin
                        state_nxt = ST_DONE;
                        resp_nxt  = 1'b1;
                    end else begin
                        state_nxt     = ST_ACCESS;
                        mem_read_nxt  = data_read;
                        mem_write_nxt = ~data_read;
                        addr_nxt      = {head_addr[31:2], 2'b00};
                        if (!data_read) begin
                            wdata_nxt = lane_data(head_f3, head_data);
                            be_nxt    = lane_mask(head_f3, head_addr[1:0]);
                        end
                    end
                end
            end
            ST_ACCESS: begin
                if (mem_resp) begin
                    state_nxt = ST_DONE;
                    resp_nxt  = 1'b1;
                    if (req_read) ld_nxt = fmt_load(req_f3, req_off, mem_rdata);
                end else begin
                    mem_read_nxt  = mem_read;
                    mem_write_nxt = mem_write;
                    addr_nxt      = mem_address;
                    wdata_nxt     = mem_wdata;
                    be_nxt        = mem_byte_enable;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_rob_mem_responder.sv
// Scoreboard bench for rob_mem_responder: cache model checks the memory side, monitor checks data_mem_resp.
module tb_rob_mem_responder;
    localparam int ROB_DEPTH = 8;
    localparam int PTR_W     = 3;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 agu_valid = 1'b0;
    logic [PTR_W-1:0]     agu_rob_idx = '0;
    logic [31:0]          agu_addr = '0;
    logic [31:0]          agu_store_data = '0;
    logic [2:0]           agu_funct3 = '0;
    logic [ROB_DEPTH-1:0] flush_mask = '0;
    logic [PTR_W-1:0]     head_ptr = '0;
    logic                 data_read = 1'b0;
    logic                 data_write = 1'b0;
    logic                 data_mem_resp;
    logic [31:0]          ld_data;
    logic                 mem_read;
    logic                 mem_write;
    logic [31:0]          mem_address;
    logic [31:0]          mem_wdata;
    logic [3:0]           mem_byte_enable;
    logic [31:0]          mem_rdata = '0;
    logic                 mem_resp = 1'b0;
    logic                 misaligned;

    rob_mem_responder #(.ROB_DEPTH(ROB_DEPTH), .PTR_W(PTR_W)) dut (
        .clk(clk), .rst(rst),
        .agu_valid(agu_valid), .agu_rob_idx(agu_rob_idx), .agu_addr(agu_addr),
        .agu_store_data(agu_store_data), .agu_funct3(agu_funct3),
        .flush_mask(flush_mask), .head_ptr(head_ptr),
        .data_read(data_read), .data_write(data_write),
        .data_mem_resp(data_mem_resp), .ld_data(ld_data),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp), .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        bit          wr;
        logic [31:0] rdata;
        int          lat;
    } mem_exp_t;

    typedef struct {
        logic [31:0] ld;
        bit          chk_ld;
        bit          mis;
    } resp_exp_t;

    mem_exp_t  mq[$];
    resp_exp_t sq[$];
    int n_checks = 0;
    int n_fail   = 0;
    bit cache_en  = 1'b1;
    bit late_resp = 1'b0;

    logic [2:0] ld_f3s [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    logic [2:0] st_f3s [3] = '{3'b000, 3'b001, 3'b010};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain arithmetic on byte offsets and widths.
    function automatic logic [31:0] model_load(input logic [2:0] f3, input int off, input logic [31:0] rdata);
        logic [31:0] lane;
        int v;
        lane = rdata >> (8 * off);
        case (f3)
            3'b000: begin v = int'(lane % 256);   if (v > 127)   v = v - 256;   end
            3'b001: begin v = int'(lane % 65536); if (v > 32767) v = v - 65536; end
            3'b100: v = int'(lane % 256);
            3'b101: v = int'(lane % 65536);
            default: v = int'(rdata);
        endcase
        return 32'(v);
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input int off);
        int b;
        if (f3 == 3'b000 || f3 == 3'b100)      b = 1 << off;
        else if (f3 == 3'b001 || f3 == 3'b101) b = (3 << off) % 16;
        else                                   b = 15;
        return 4'(b);
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
        if (f3 == 3'b000) return (d % 256) * 32'h0101_0101;
        if (f3 == 3'b001) return (d % 65536) * 32'h0001_0001;
        return d;
    endfunction

    function automatic bit model_mis(input logic [2:0] f3, input int off);
`ifdef MEM_MISALIGN_CHECK_EN
        return ((f3 == 3'b001 || f3 == 3'b101) && (off % 2 == 1)) || (f3 == 3'b010 && off != 0);
`else
        return 1'b0;
`endif
    endfunction

    // Cache model: checks request fields, holds for lat cycles, then responds.
    initial begin
        mem_exp_t me;
        forever begin
            @(negedge clk);
            if (!cache_en) begin
                mem_resp = late_resp;
            end else if (mem_read || mem_write) begin
                if (mq.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_mem_req: got addr %h expected no request", mem_address);
                end else begin
                    me = mq.pop_front();
                    check("mem_address", mem_address, me.addr);
                    check("mem_write", 32'(mem_write), 32'(me.wr));
                    check("mem_read", 32'(mem_read), 32'(!me.wr));
                    check("byte_enable", 32'(mem_byte_enable), 32'(me.be));
                    if (me.wr) check("mem_wdata", mem_wdata, me.wdata);
                    for (int k = 1; k < me.lat; k++) begin
                        @(negedge clk);
                        check("req_held", 32'(mem_read | mem_write), 32'd1);
                        check("addr_stable", mem_address, me.addr);
                    end
                    mem_rdata = me.rdata;
                    mem_resp  = 1'b1;
                    @(negedge clk);
                    mem_resp  = 1'b0;
                    mem_rdata = $urandom;
                    check("req_dropped", 32'(mem_read | mem_write), 32'd0);
                end
            end else begin
                mem_resp = 1'b0;
            end
        end
    end

    // Response monitor.
    initial begin
        resp_exp_t re;
        forever begin
            @(negedge clk);
            if (data_mem_resp) begin
                if (sq.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_resp: got data_mem_resp=1 expected 0 at %0t", $time);
                end else begin
                    re = sq.pop_front();
                    if (re.chk_ld) check("ld_data", ld_data, re.ld);
                    check("misaligned", 32'(misaligned), 32'(re.mis));
                end
            end else if (misaligned) begin
                check("mis_without_resp", 32'(misaligned), 32'd0);
            end
        end
    end

    task automatic run_txn(input logic [2:0] idx, input logic [31:0] addr, input logic [31:0] data,
                           input logic [2:0] f3, input bit rd, input bit both,
                           input logic [31:0] rdata, input int lat, input int stall);
        bit mis;
        bit got;
        int cnt;
        int off;
        mem_exp_t me;
        resp_exp_t re;
        off = int'(addr % 4);
        mis = model_mis(f3, off);
        flush_mask = 8'(1) << idx;
        @(negedge clk);
        flush_mask = '0;
        if (!mis) begin
            me.addr  = addr - 32'(off);
            me.wr    = !rd;
            me.be    = rd ? 4'd0 : model_be(f3, off);
            me.wdata = model_wdata(f3, data);
            me.rdata = rdata;
            me.lat   = lat;
            mq.push_back(me);
        end
        re.ld     = mis ? 32'd0 : model_load(f3, off, rdata);
        re.chk_ld = rd || mis;
        re.mis    = mis;
        sq.push_back(re);
        head_ptr   = idx;
        data_read  = rd;
        data_write = !rd || both;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check("stall_no_req", 32'({mem_read, mem_write}), 32'd0);
        end
        agu_valid = 1'b1; agu_rob_idx = idx; agu_addr = addr;
        agu_store_data = data; agu_funct3 = f3;
        got = 1'b0;
        cnt = 0;
        while (!got && cnt < lat + 40) begin
            @(negedge clk);
            cnt++;
            if (data_mem_resp) begin
                got = 1'b1;
            end else begin
                agu_valid      = ($urandom % 4 == 0);
                agu_rob_idx    = idx + 3'(1 + $urandom % 7);
                agu_addr       = $urandom;
                agu_store_data = $urandom;
                agu_funct3     = 3'($urandom);
                flush_mask     = ($urandom % 4 == 0) ? 8'($urandom) : 8'd0;
            end
        end
        agu_valid  = 1'b0;
        flush_mask = '0;
        check("resp_seen", 32'(got), 32'd1);
        check("resp_latency", 32'(cnt), 32'(mis ? 2 : lat + 2));
        repeat (2) begin
            @(negedge clk);
            check("no_reissue", 32'({mem_read, mem_write}), 32'd0);
        end
        data_read  = 1'b0;
        data_write = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        mem_exp_t me;
        resp_exp_t re;
        int cnt;
        bit got;
        logic [31:0] r;

        repeat (3) @(negedge clk);
        check("rst_mem_read", 32'(mem_read), 32'd0);
        check("rst_mem_write", 32'(mem_write), 32'd0);
        check("rst_resp", 32'(data_mem_resp), 32'd0);
        check("rst_ld_data", ld_data, 32'd0);
        check("rst_address", mem_address, 32'd0);
        check("rst_be", 32'(mem_byte_enable), 32'd0);
        check("rst_misaligned", 32'(misaligned), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_txn(3'd2, 32'h100, 32'h0, 3'b010, 1'b1, 1'b0, 32'hDEADBEEF, 3, 0);
        run_txn(3'd1, 32'h103, 32'h0, 3'b000, 1'b1, 1'b0, 32'h80FF_0000, 2, 0);
        run_txn(3'd1, 32'h103, 32'h0, 3'b100, 1'b1, 1'b0, 32'h80FF_0000, 2, 0);
        run_txn(3'd3, 32'h202, 32'h1234ABCD, 3'b001, 1'b0, 1'b0, 32'h0, 2, 0);
        run_txn(3'd0, 32'h40, 32'h0, 3'b010, 1'b1, 1'b0, 32'h1357_9BDF, 2, 5);
        run_txn(3'd6, 32'h82, 32'h0, 3'b101, 1'b1, 1'b1, 32'hF00D_8001, 1, 0);
        run_txn(3'd7, 32'h101, 32'h0, 3'b010, 1'b1, 1'b0, 32'hCAFE_F00D, 2, 0);
        run_txn(3'd0, 32'h301, 32'hAAAA_5555, 3'b001, 1'b0, 1'b0, 32'h0, 1, 0);

        // Flush all entries while writing entry 4 in the same cycle.
        for (int i = 0; i < 8; i++) begin
            agu_valid = 1'b1; agu_rob_idx = 3'(i); agu_addr = 32'h400 + 32'(i * 4);
            agu_funct3 = 3'b010; agu_store_data = 32'h0;
            @(negedge clk);
        end
        flush_mask = 8'hFF; agu_rob_idx = 3'd4; agu_addr = 32'h440;
        @(negedge clk);
        agu_valid = 1'b0; flush_mask = '0;
        for (int i = 0; i < 8; i++) begin
            if (i != 4) begin
                head_ptr = 3'(i); data_read = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    check("flushed_no_req", 32'({mem_read, mem_write}), 32'd0);
                end
                data_read = 1'b0;
                @(negedge clk);
            end
        end
        r = $urandom;
        me.addr = 32'h440; me.wr = 1'b0; me.be = 4'd0; me.wdata = 32'h0; me.rdata = r; me.lat = 2;
        mq.push_back(me);
        re.ld = r; re.chk_ld = 1'b1; re.mis = 1'b0;
        sq.push_back(re);
        head_ptr = 3'd4; data_read = 1'b1;
        got = 1'b0; cnt = 0;
        while (!got && cnt < 40) begin
            @(negedge clk);
            cnt++;
            if (data_mem_resp) got = 1'b1;
        end
        check("flush_keep_resp", 32'(got), 32'd1);
        check("flush_keep_latency", 32'(cnt), 32'd3);
        data_read = 1'b0;
        @(negedge clk);

        // Reset while a read is outstanding; a late mem_resp must be ignored.
        cache_en = 1'b0;
        agu_valid = 1'b1; agu_rob_idx = 3'd5; agu_addr = 32'h300; agu_funct3 = 3'b010;
        head_ptr = 3'd5; data_read = 1'b1;
        @(negedge clk);
        agu_valid = 1'b0;
        got = 1'b0; cnt = 0;
        while (!got && cnt < 10) begin
            @(negedge clk);
            cnt++;
            if (mem_read) got = 1'b1;
        end
        check("rst_test_req_seen", 32'(got), 32'd1);
        rst = 1'b1; data_read = 1'b0;
        @(negedge clk);
        check("rst_drop_read", 32'(mem_read), 32'd0);
        check("rst_no_resp", 32'(data_mem_resp), 32'd0);
        rst = 1'b0; late_resp = 1'b1;
        @(negedge clk);
        late_resp = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("post_rst_idle", 32'({mem_read, mem_write, data_mem_resp}), 32'd0);
        end
        cache_en = 1'b1;
        @(negedge clk);

        for (int t = 0; t < 150; t++) begin
            bit rd;
            logic [2:0] f3;
            rd = 1'($urandom % 2);
            f3 = rd ? ld_f3s[$urandom % 5] : st_f3s[$urandom % 3];
            run_txn(3'($urandom), $urandom, $urandom, f3, rd, rd && ($urandom % 4 == 0),
                    $urandom, 1 + int'($urandom % 4), int'($urandom % 3));
        end

        repeat (5) @(negedge clk);
        check("resp_queue_empty", 32'(sq.size()), 32'd0);
        check("mem_queue_empty", 32'(mq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
